// File: rtl/if_fetch_stage_if.sv
// Instruction-memory read port between the fetch stage (master) and memory (slave).
interface if_fetch_stage_if #(
  parameter int W = 16
);
  // i_readM is held while a read is outstanding. i_address is stable while i_readM is high.
  // The read completes on the clock edge where i_inputReady is 1, and i_data is valid on that same edge.
  // i_inputReady is ignored whenever i_readM is low.
  logic         i_readM;
  logic [W-1:0] i_address;
  logic [W-1:0] i_data;
  logic         i_inputReady;

  modport master (
    output i_readM,
    output i_address,
    input  i_data,
    input  i_inputReady
  );

  modport slave (
    input  i_readM,
    input  i_address,
    output i_data,
    output i_inputReady
  );
endinterface

// File: rtl/if_fetch_stage.sv
// Pipeline instruction-fetch stage: owns the PC, reads instruction memory and hands one word at a time to IF/ID.
// Optional macro IF_FETCH_COUNT_EN adds a fetch_count output that counts completed transfers.
module if_fetch_stage #(
  parameter int                   WORD_SIZE = 16,
  parameter logic [WORD_SIZE-1:0] RESET_PC  = '0
) (
  input  logic                 Clk,
  input  logic                 Reset_N,
  input  logic                 stall,
  input  logic                 redirect,
  input  logic [WORD_SIZE-1:0] redirect_target,
  if_fetch_stage_if.master     imem,
  output logic [WORD_SIZE-1:0] PCSource,
  output logic [WORD_SIZE-1:0] instruction,
  output logic                 fetch_valid,
  output logic                 IF_ID_Flush,
`ifdef IF_FETCH_COUNT_EN
  output logic [WORD_SIZE-1:0] fetch_count,
`endif
  output logic [1:0]           dbg_state
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    FETCH   = 2'd1,
    DELIVER = 2'd2
  } state_e;

  state_e               state_q, state_d;
  logic [WORD_SIZE-1:0] pc_q, pc_d;
  logic [WORD_SIZE-1:0] instr_q, instr_d;
  logic [WORD_SIZE-1:0] pcsrc_q, pcsrc_d;
  logic [WORD_SIZE-1:0] pc_plus1;
  logic                 xfer_done;
  logic                 read_req;
  logic                 valid_raw;
  logic                 flush_raw;

  assign pc_plus1 = pc_q + WORD_SIZE'(1);

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    instr_d   = instr_q;
    pcsrc_d   = pcsrc_q;
    read_req  = 1'b0;
    valid_raw = 1'b0;
    flush_raw = 1'b0;
    xfer_done = 1'b0;

    case (state_q)
      IDLE: begin
        state_d = FETCH;
      end

      FETCH: begin
        read_req = 1'b1;
        if (redirect) begin
          flush_raw = 1'b1;
          pc_d      = redirect_target;
        end else if (imem.i_inputReady) begin
          instr_d = imem.i_data;
          pcsrc_d = pc_plus1;
          pc_d    = pc_plus1;
          state_d = DELIVER;
        end
      end

      DELIVER: begin
        // A redirect kills the held word in the same cycle, so IF/ID never latches it.
        if (redirect) begin
          flush_raw = 1'b1;
          pc_d      = redirect_target;
          state_d   = FETCH;
        end else begin
          valid_raw = 1'b1;
          if (!stall) begin
            xfer_done = 1'b1;
            state_d   = FETCH;
          end
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Reset is synchronous, but the outputs are silenced as soon as Reset_N falls.
  assign imem.i_readM   = read_req & Reset_N;
  assign imem.i_address = pc_q;
  assign fetch_valid    = valid_raw & Reset_N;
  assign IF_ID_Flush    = flush_raw & Reset_N;
  assign instruction    = instr_q;
  assign PCSource       = pcsrc_q;
  assign dbg_state      = state_q;

  always_ff @(posedge Clk) begin
    if (!Reset_N) begin
      state_q <= IDLE;
      pc_q    <= RESET_PC;
      instr_q <= '0;
      pcsrc_q <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      pcsrc_q <= pcsrc_d;
    end
  end

`ifdef IF_FETCH_COUNT_EN
  logic [WORD_SIZE-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (xfer_done) begin
      count_d = count_q + WORD_SIZE'(1);
    end
  end

  always_ff @(posedge Clk) begin
    if (!Reset_N) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign fetch_count = count_q;
`endif

endmodule

// File: tb/tb_if_fetch_stage.sv
// Bench for if_fetch_stage: directed scenarios, then randomized traffic against a queue-based reference model.
module tb_if_fetch_stage;
  localparam int         W        = 16;
  localparam logic [W-1:0] RESET_PC = 16'h0000;

  // Clock and reset
  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         stall = 1'b0;
  logic         redirect = 1'b0;
  logic [W-1:0] redirect_target = '0;
  logic [W-1:0] PCSource;
  logic [W-1:0] instruction;
  logic         fetch_valid;
  logic         IF_ID_Flush;
  logic [1:0]   dbg_state;
`ifdef IF_FETCH_COUNT_EN
  logic [W-1:0] fetch_count;
`endif

  always #5 clk = ~clk;

  if_fetch_stage_if #(.W(W)) imem ();

  if_fetch_stage #(.WORD_SIZE(W), .RESET_PC(RESET_PC)) dut (
    .Clk             (clk),
    .Reset_N         (rst_n),
    .stall           (stall),
    .redirect        (redirect),
    .redirect_target (redirect_target),
    .imem            (imem),
    .PCSource        (PCSource),
    .instruction     (instruction),
    .fetch_valid     (fetch_valid),
    .IF_ID_Flush     (IF_ID_Flush),
`ifdef IF_FETCH_COUNT_EN
    .fetch_count     (fetch_count),
`endif
    .dbg_state       (dbg_state)
  );

  // Scoreboard: exp_q holds {PC+1, word} for a fetched word that is waiting to be delivered.
  logic [2*W-1:0] exp_q[$];
  logic [W-1:0]   exp_pc;
  bit             known = 1'b0;
  bit             idle = 1'b0;
  int             exp_count = 0;
  int             errors = 0;
  int             checks = 0;

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Drives one cycle of inputs, checks the outputs mid-cycle, then advances the model across the coming edge.
  task automatic cycle(input bit r, input bit st, input bit rd, input logic [W-1:0] tgt,
                       input bit rdy, input logic [W-1:0] dat);
    bit live;
    bit exp_valid;
    @(negedge clk);
    rst_n = r; stall = st; redirect = rd; redirect_target = tgt;
    imem.i_inputReady = rdy; imem.i_data = dat;
    #1;
    if (known) begin
      live      = r && !idle;
      exp_valid = live && exp_q.size() != 0 && !rd;
      chk("i_readM", W'(imem.i_readM), W'(live && exp_q.size() == 0));
      chk("fetch_valid", W'(fetch_valid), W'(exp_valid));
      chk("IF_ID_Flush", W'(IF_ID_Flush), W'(live && rd));
      if (r) chk("i_address", imem.i_address, exp_pc);
      if (exp_valid) begin
        chk("PCSource", PCSource, exp_q[0][2*W-1:W]);
        chk("instruction", instruction, exp_q[0][W-1:0]);
      end
`ifdef IF_FETCH_COUNT_EN
      chk("fetch_count", fetch_count, W'(exp_count));
`endif
    end
    if (!r) begin
      known = 1'b1; idle = 1'b1; exp_pc = RESET_PC; exp_q.delete(); exp_count = 0;
    end else if (known) begin
      if (idle) idle = 1'b0;
      else if (rd) begin
        exp_pc = tgt; exp_q.delete();
      end else if (exp_q.size() != 0) begin
        if (!st) begin
          void'(exp_q.pop_front()); exp_count++;
        end
      end else if (rdy) begin
        exp_q.push_back({exp_pc + W'(1), dat});
        exp_pc = exp_pc + W'(1);
      end
    end
  endtask

  initial begin
    imem.i_inputReady = 1'b0;
    imem.i_data = '0;

    // Reset, then the single idle cycle
    cycle(0, 0, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 0, 0);
    chk("rst_instruction", instruction, 16'h0000);
    chk("rst_pcsource", PCSource, 16'h0000);
    cycle(1, 0, 0, 0, 0, 0);

    // Zero-wait memory, two instructions
    cycle(1, 0, 0, 0, 1, 16'h1111);
    chk("tp1_addr0", imem.i_address, 16'h0000);
    cycle(1, 0, 0, 0, 0, 0);
    chk("tp1_instr0", instruction, 16'h1111);
    chk("tp1_pcs0", PCSource, 16'h0001);
    cycle(1, 0, 0, 0, 1, 16'h2222);
    chk("tp1_addr1", imem.i_address, 16'h0001);
    cycle(1, 0, 0, 0, 0, 0);
    chk("tp1_instr1", instruction, 16'h2222);
    chk("tp1_pcs1", PCSource, 16'h0002);

    // Three wait cycles at PC 0005
    cycle(1, 0, 1, 16'h0005, 0, 0);
    for (int i = 0; i < 3; i++) begin
      cycle(1, 0, 0, 0, 0, 0);
      chk("tp2_addr_wait", imem.i_address, 16'h0005);
    end
    cycle(1, 0, 0, 0, 1, 16'h5555);
    chk("tp2_readm_last", W'(imem.i_readM), 16'h0001);
    cycle(1, 0, 0, 0, 0, 0);
    chk("tp2_valid", W'(fetch_valid), 16'h0001);
    chk("tp2_pcs", PCSource, 16'h0006);

    // Stall holds a delivered word
    cycle(1, 0, 0, 0, 1, 16'hABCD);
    for (int i = 0; i < 5; i++) begin
      cycle(1, 1, 0, 0, 1, 16'h0BAD);
      chk("tp3_instr_hold", instruction, 16'hABCD);
      chk("tp3_pc_hold", imem.i_address, 16'h0007);
    end
    cycle(1, 0, 0, 0, 0, 0);
    cycle(1, 0, 0, 0, 0, 0);
    chk("tp3_next_addr", imem.i_address, 16'h0007);

    // Redirect coincident with the memory response
    cycle(1, 0, 1, 16'h0040, 1, 16'hDEAD);
    chk("tp4_flush", W'(IF_ID_Flush), 16'h0001);
    cycle(1, 0, 0, 0, 1, 16'h4040);
    chk("tp4_addr", imem.i_address, 16'h0040);
    cycle(1, 0, 0, 0, 0, 0);
    chk("tp4_pcs", PCSource, 16'h0041);
    chk("tp4_instr", instruction, 16'h4040);

    // PC wrap, then reset in the middle of a fetch
    cycle(1, 0, 1, 16'hFFFF, 0, 0);
    cycle(1, 0, 0, 0, 1, 16'h7777);
    cycle(1, 0, 0, 0, 0, 0);
    chk("tp5_pcs_wrap", PCSource, 16'h0000);
    cycle(1, 0, 0, 0, 0, 0);
    chk("tp5_addr_wrap", imem.i_address, 16'h0000);
    cycle(0, 0, 0, 0, 1, 16'h9999);
    cycle(1, 0, 0, 0, 1, 16'h9999);
    chk("tp5_rst_readm", W'(imem.i_readM), 16'h0000);
    chk("tp5_rst_pc", imem.i_address, RESET_PC);

`ifdef IF_FETCH_COUNT_EN
    // Three completed transfers and one discarded by redirect
    cycle(1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      cycle(1, 0, 0, 0, 1, W'(16'h3000 + i));
      cycle(1, 0, 0, 0, 0, 0);
    end
    cycle(1, 0, 0, 0, 1, 16'h3333);
    cycle(1, 0, 1, 16'h0100, 0, 0);
    cycle(1, 0, 0, 0, 0, 0);
    chk("tp6_count", fetch_count, 16'h0003);
`endif

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      logic [W-1:0] tgt;
      tgt = ($urandom_range(0, 3) == 0) ? W'(16'hFFFE + $urandom_range(0, 1)) : W'($urandom);
      cycle($urandom_range(0, 299) != 0, $urandom_range(0, 3) == 0, $urandom_range(0, 15) == 0,
            tgt, $urandom_range(0, 2) != 0, W'($urandom));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
